// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: per-channel synchroniser chain followed by a
// stability counter that accepts a new level only after it has held long enough.
module debounce_bank #(
    parameter int   N_CH         = 4,
    parameter int   SYNC_STAGES  = 2,
    parameter int   STABLE_COUNT = 50000,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_tick,
    input  logic [N_CH-1:0] d_in,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_pending,
    output logic            o_any_change
);

    localparam int                CNT_W    = $clog2(STABLE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_CH-1:0] w_rise_nxt;
    logic [N_CH-1:0] w_fall_nxt;
    logic            r_any_change;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_level;
        logic                   r_rise;
        logic                   r_fall;
        logic                   w_sync;
        logic [CNT_W-1:0]       w_cnt_nxt;
        logic                   w_level_nxt;
        logic                   w_rise;
        logic                   w_fall;

        // Synchroniser: shifts every clock regardless of i_tick
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_sync <= {SYNC_STAGES{RESET_LEVEL}};
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], d_in[c]};
            end
        end

        assign w_sync = r_sync[SYNC_STAGES-1];

        // Stability counter: a bounce back to the current level clears the
        // count immediately, even on clocks without a tick.
        always_comb begin
            w_cnt_nxt   = r_cnt;
            w_level_nxt = r_level;
            w_rise      = 1'b0;
            w_fall      = 1'b0;
            if (w_sync == r_level) begin
                w_cnt_nxt = '0;
            end else if (i_tick) begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_level_nxt = w_sync;
                    w_rise      = w_sync;
                    w_fall      = ~w_sync;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_cnt   <= '0;
                r_level <= RESET_LEVEL;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_cnt   <= w_cnt_nxt;
                r_level <= w_level_nxt;
                r_rise  <= w_rise;
                r_fall  <= w_fall;
            end
        end

        assign w_rise_nxt[c] = w_rise;
        assign w_fall_nxt[c] = w_fall;
        assign o_level[c]    = r_level;
        assign o_rise[c]     = r_rise;
        assign o_fall[c]     = r_fall;
        // Pending is held low during reset because both sides reset to RESET_LEVEL
        assign o_pending[c]  = w_sync ^ r_level;
    end

    // Summary flag registered from the next-state pulses so it lines up with them
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_any_change <= 1'b0;
        end else begin
            r_any_change <= |(w_rise_nxt | w_fall_nxt);
        end
    end

    assign o_any_change = r_any_change;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: pulse scoreboard on the main instance,
// tick-gated second instance checked cycle by cycle.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_a;
    logic       tick_b;
    logic [3:0] d_a;
    logic [3:0] d_b;
    logic [3:0] level_a, rise_a, fall_a, pend_a;
    logic [3:0] level_b, rise_b, fall_b, pend_b;
    logic       any_a, any_b;

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    debounce_bank #(.N_CH(4), .SYNC_STAGES(2), .STABLE_COUNT(4), .RESET_LEVEL(1'b0)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_tick(tick_a), .d_in(d_a),
        .o_level(level_a), .o_rise(rise_a), .o_fall(fall_a),
        .o_pending(pend_a), .o_any_change(any_a)
    );

    debounce_bank #(.N_CH(4), .SYNC_STAGES(2), .STABLE_COUNT(3), .RESET_LEVEL(1'b0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_tick(tick_b), .d_in(d_b),
        .o_level(level_b), .o_rise(rise_b), .o_fall(fall_b),
        .o_pending(pend_b), .o_any_change(any_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance to the next falling edge; tick_b strobes every 4th rising edge
    task automatic cyc();
        @(negedge clk);
        tick_b = (((ecnt + 1) % 4) == 0);
    endtask

    // Pulse scoreboard for instance A
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == ecnt) begin
            mon_e = exp_q.pop_front();
            chk("sb_rise", rise_a, mon_e.rise);
            chk("sb_fall", fall_a, mon_e.fall);
            chk("sb_any", any_a, 1);
        end else if ((|rise_a) || (|fall_a) || any_a) begin
            chk("spurious_rise", rise_a, 0);
            chk("spurious_fall", fall_a, 0);
            chk("spurious_any", any_a, 0);
        end
    end

    initial begin
        int m;
        int r;
        int e;
        int n;
        int t;

        rst = 1'b0; tick_a = 1'b1; tick_b = 1'b0; d_a = '0; d_b = '0;

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        chk("rst_level", level_a, 0);
        chk("rst_rise", rise_a, 0);
        chk("rst_fall", fall_a, 0);
        chk("rst_pend", pend_a, 0);
        chk("rst_any", any_a, 0);
        chk("rst_level_b", level_b, 0);
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // Clean press on channel 0
        d_a[0] = 1'b1;
        m = ecnt;
        exp_q.push_back('{m + 6, 4'b0001, 4'b0000});
        repeat (8) begin
            cyc();
            chk("press_pend0", pend_a[0], (ecnt >= m + 2 && ecnt <= m + 5));
            chk("press_level0", level_a[0], (ecnt >= m + 6));
        end

        // Bounce on channel 1, then settle high
        for (int p = 0; p < 4; p++) begin
            d_a[1] = (p % 2 == 0);
            repeat (3) begin
                cyc();
                chk("bounce_level1", level_a[1], 0);
            end
        end
        d_a[1] = 1'b1;
        m = ecnt;
        exp_q.push_back('{m + 6, 4'b0010, 4'b0000});
        repeat (8) begin
            cyc();
            chk("settle_level1", level_a[1], (ecnt >= m + 6));
        end

        // Tick-gated acceptance on instance B channel 2
        d_b[2] = 1'b1;
        m = ecnt;
        n = 0;
        e = m + 2;
        while (n < 3) begin
            e++;
            if (e % 4 == 0) n++;
        end
        t = e;
        while (ecnt < t + 2) begin
            cyc();
            chk("tick_level2", level_b[2], (ecnt >= t));
            chk("tick_rise2", rise_b[2], (ecnt == t));
            chk("tick_pend2", pend_b[2], (ecnt >= m + 2 && ecnt < t));
            chk("tick_fall_b", fall_b, 0);
        end

        // Channel 3 up, then channels 0 and 3 released together
        d_a[3] = 1'b1;
        m = ecnt;
        exp_q.push_back('{m + 6, 4'b1000, 4'b0000});
        repeat (7) cyc();
        chk("multi_level_hi", level_a, 4'b1011);
        d_a[0] = 1'b0;
        d_a[3] = 1'b0;
        m = ecnt;
        exp_q.push_back('{m + 6, 4'b0000, 4'b1001});
        repeat (7) cyc();
        chk("multi_level_lo", level_a, 4'b0010);

        // Reset in the middle of a count on channel 2
        d_a[2] = 1'b1;
        repeat (4) cyc();
        chk("midcnt_pend2", pend_a[2], 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_level", level_a, 0);
        chk("midrst_pend", pend_a, 0);
        chk("midrst_rise", rise_a, 0);
        chk("midrst_fall", fall_a, 0);
        repeat (3) cyc();
        rst = 1'b0;
        r = ecnt;
        exp_q.push_back('{r + 6, 4'b0110, 4'b0000});
        repeat (8) begin
            cyc();
            chk("restart_level2", level_a[2], (ecnt >= r + 6));
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
